// File: rtl/maze_memory_pkg.sv
// ============================================================================
// Module      : maze_memory_pkg
// Description : Shared constants and state encoding for the maze store.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maze_memory_pkg;

    localparam int DIM     = 16;
    localparam int COORD_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        READY   = 2'd2,
        RESTORE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/maze_mem_ctrl.sv
// ============================================================================
// Module      : maze_mem_ctrl
// Description : Load/restore sequencer and row counter for maze_memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_mem_ctrl
    import maze_memory_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               row_valid,
    input  logic               clear_marks,
    output logic [COORD_W-1:0] row,
    output logic               row_ready,
    output logic               ready,
    output logic               load_we,
    output logic               restore_we
);

    localparam logic [COORD_W-1:0] c_last_row = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] w_row_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        row_ready    = 1'b0;
        ready        = 1'b0;
        load_we      = 1'b0;
        restore_we   = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_state_next = LOAD;
                    w_row_next   = '0;
                end
            end
            LOAD: begin
                row_ready = 1'b1;
                if (row_valid) begin
                    load_we    = 1'b1;
                    w_row_next = r_row + 1'b1;
                    if (r_row == c_last_row) begin
                        w_state_next = READY;
                    end
                end
            end
            READY: begin
                ready = 1'b1;
                // A new load takes priority over a mark wipe.
                if (load_start) begin
                    w_state_next = LOAD;
                    w_row_next   = '0;
                end else if (clear_marks) begin
                    w_state_next = RESTORE;
                    w_row_next   = '0;
                end
            end
            RESTORE: begin
                restore_we = 1'b1;
                w_row_next = r_row + 1'b1;
                if (r_row == c_last_row) begin
                    w_state_next = READY;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_row_next   = '0;
            end
        endcase
    end

    assign row = r_row;

endmodule

`default_nettype wire

// File: rtl/maze_memory.sv
// ============================================================================
// Module      : maze_memory
// Description : 16x16 maze wall map with pristine copy, rat read/write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_memory
    import maze_memory_pkg::COORD_W;
#(
    parameter int DIM = maze_memory_pkg::DIM
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load_start,
    input  logic [DIM-1:0]     row_data,
    input  logic               row_valid,
    output logic               row_ready,
    input  logic               clear_marks,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    input  logic               RD,
    input  logic               WR,
    input  logic               D_in,
    output logic               D_out,
    output logic               ready,
    output logic               access_err
);

    generate
        if (DIM != (1 << COORD_W)) begin : g_dim_check
            $error("maze_memory: DIM must equal 2**COORD_W");
        end
    endgenerate

    logic [COORD_W-1:0] w_row;
    logic               w_load_we;
    logic               w_restore_we;
    logic               w_ready;

    logic [DIM-1:0] r_orig [DIM];
    logic [DIM-1:0] r_work [DIM];
    logic           r_d_out;
    logic           r_access_err;

    maze_mem_ctrl u_ctrl (
        .clk         (CLK),
        .rst         (RST),
        .load_start  (load_start),
        .row_valid   (row_valid),
        .clear_marks (clear_marks),
        .row         (w_row),
        .row_ready   (row_ready),
        .ready       (w_ready),
        .load_we     (w_load_we),
        .restore_we  (w_restore_we)
    );

    // Arrays carry no reset; their contents are meaningless until a load completes.
    always_ff @(posedge CLK) begin
        if (w_load_we) begin
            r_orig[w_row] <= row_data;
            r_work[w_row] <= row_data;
        end else if (w_restore_we) begin
            r_work[w_row] <= r_orig[w_row];
        end else if (w_ready && WR) begin
            r_work[Y][X] <= D_in;
        end
    end

    // Read samples the pre-write contents, giving read-before-write on a shared cell.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_d_out      <= 1'b0;
            r_access_err <= 1'b0;
        end else begin
            r_access_err <= (RD || WR) && !w_ready;
            if (RD && w_ready) begin
                r_d_out <= r_work[Y][X];
            end
        end
    end

    assign D_out      = r_d_out;
    assign access_err = r_access_err;
    assign ready      = w_ready;

endmodule

`default_nettype wire

// File: tb/tb_maze_memory.sv
// ============================================================================
// Module      : tb_maze_memory
// Description : Scoreboard bench for maze_memory load, rat access and restore.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maze_memory;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        load_start = 1'b0;
    logic [15:0] row_data = '0;
    logic        row_valid = 1'b0;
    logic        row_ready;
    logic        clear_marks = 1'b0;
    logic [3:0]  X = '0;
    logic [3:0]  Y = '0;
    logic        RD = 1'b0;
    logic        WR = 1'b0;
    logic        D_in = 1'b0;
    logic        D_out;
    logic        ready;
    logic        access_err;

    int          total = 0;
    int          bad = 0;
    logic        exp_q [$];
    logic [15:0] pat    [16];
    logic [15:0] m_orig [16];
    logic [15:0] m_work [16];
    logic        m_ready = 1'b0;
    logic        m_dout = 1'b0;

    maze_memory #(.DIM(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .load_start  (load_start),
        .row_data    (row_data),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .clear_marks (clear_marks),
        .X           (X),
        .Y           (Y),
        .RD          (RD),
        .WR          (WR),
        .D_in        (D_in),
        .D_out       (D_out),
        .ready       (ready),
        .access_err  (access_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One rat access cycle; the model predicts D_out and access_err.
    task automatic access(input int x, input int y, input logic rd, input logic wr, input logic d);
        logic e_err;
        logic e_dout;
        X = x[3:0]; Y = y[3:0]; RD = rd; WR = wr; D_in = d;
        e_err = (rd | wr) & ~m_ready;
        if (rd && m_ready) m_dout = m_work[y][x];
        if (wr && m_ready) m_work[y][x] = d;
        exp_q.push_back(m_dout);
        tick();
        RD = 1'b0; WR = 1'b0;
        e_dout = exp_q.pop_front();
        total++;
        if (D_out !== e_dout) begin
            bad++;
            $display("FAIL d_out (%0d,%0d) got=%b exp=%b", x, y, D_out, e_dout);
        end
        total++;
        if (access_err !== e_err) begin
            bad++;
            $display("FAIL access_err (%0d,%0d) got=%b exp=%b", x, y, access_err, e_err);
        end
    endtask

    task automatic load_maze(input bit stall, input bit with_clear);
        int   acc;
        int   cyc;
        logic go;
        total++;
        if (row_ready !== 1'b0) begin
            bad++;
            $display("FAIL row_ready_before_load got=%b exp=0", row_ready);
        end
        load_start = 1'b1; clear_marks = with_clear;
        tick();
        load_start = 1'b0; clear_marks = 1'b0;
        m_ready = 1'b0;
        total++;
        if (row_ready !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL load_enter row_ready=%b ready=%b exp=1/0", row_ready, ready);
        end
        acc = 0; cyc = 0;
        while (acc < 16 && cyc < 200) begin
            row_valid = stall ? (cyc % 2 == 1) : 1'b1;
            row_data  = pat[acc];
            go = row_valid & row_ready;
            total++;
            if (ready !== 1'b0) begin
                bad++;
                $display("FAIL ready_during_load row=%0d got=%b exp=0", acc, ready);
            end
            tick();
            if (go) acc++;
            cyc++;
        end
        row_valid = 1'b0;
        total++;
        if (acc != 16) begin
            bad++;
            $display("FAIL load_timeout rows=%0d exp=16", acc);
        end
        if (!stall) begin
            total++;
            if (cyc != 16) begin
                bad++;
                $display("FAIL load_cycles got=%0d exp=16", cyc);
            end
        end
        total++;
        if (ready !== 1'b1 || row_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_done ready=%b row_ready=%b exp=1/0", ready, row_ready);
        end
        m_orig = pat; m_work = pat; m_ready = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        total++;
        if (row_ready !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags row_ready=%b ready=%b exp=0/0", row_ready, ready);
        end
        total++;
        if (D_out !== 1'b0 || access_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_out d_out=%b err=%b exp=0/0", D_out, access_err);
        end
        RST = 1'b0;
        tick();
        total++;
        if (row_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_row_ready got=%b exp=0", row_ready);
        end
        access(0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_load_basic();
        for (int n = 0; n < 16; n++) pat[n] = 16'h0001 << n;
        load_maze(1'b0, 1'b0);
        access(3, 3, 1'b1, 1'b0, 1'b0);
        access(4, 3, 1'b1, 1'b0, 1'b0);
        access(15, 15, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_rw();
        access(5, 2, 1'b0, 1'b1, 1'b1);
        access(5, 2, 1'b1, 1'b0, 1'b0);
        access(6, 2, 1'b1, 1'b1, 1'b1);
        access(0, 0, 1'b0, 1'b0, 1'b0);
        access(6, 2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_restore();
        clear_marks = 1'b1;
        tick();
        clear_marks = 1'b0;
        m_ready = 1'b0;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL restore_enter ready=%b exp=0", ready);
        end
        for (int k = 0; k < 16; k++) begin
            if (k == 3) access(0, 0, 1'b1, 1'b1, 1'b0);
            else tick();
            if (k == 15) begin
                m_ready = 1'b1;
                m_work = m_orig;
            end
            total++;
            if (ready !== m_ready) begin
                bad++;
                $display("FAIL restore_ready k=%0d got=%b exp=%b", k, ready, m_ready);
            end
            if (k == 4) begin
                total++;
                if (access_err !== 1'b0) begin
                    bad++;
                    $display("FAIL err_pulse_width got=%b exp=0", access_err);
                end
            end
        end
        access(5, 2, 1'b1, 1'b0, 1'b0);
        access(6, 2, 1'b1, 1'b0, 1'b0);
        access(0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_load_stall();
        for (int n = 0; n < 16; n++) pat[n] = 16'($urandom);
        load_maze(1'b1, 1'b0);
        for (int y = 0; y < 16; y++) access($urandom_range(15), y, 1'b1, 1'b0, 1'b0);
        for (int y = 0; y < 16; y += 5) access(y, y, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid_load();
        for (int n = 0; n < 16; n++) pat[n] = 16'h0001 << n;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int n = 0; n < 7; n++) begin
            row_valid = 1'b1; row_data = 16'hffff;
            tick();
        end
        row_data = 16'hffff;
        #2 RST = 1'b1;
        #1;
        m_ready = 1'b0; m_dout = 1'b0;
        total++;
        if (row_ready !== 1'b0 || ready !== 1'b0 || D_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_abort row_ready=%b ready=%b d_out=%b exp=0/0/0", row_ready, ready, D_out);
        end
        tick();
        RST = 1'b0; row_valid = 1'b0;
        tick();
        access(2, 2, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 16; n++) pat[n] = 16'($urandom);
        load_maze(1'b0, 1'b0);
        for (int y = 0; y < 16; y += 3) access(15 - y, y, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        access(7, 7, 1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 16; n++) pat[n] = 16'($urandom);
        load_maze(1'b0, 1'b1);
        access(7, 7, 1'b1, 1'b0, 1'b0);
        for (int y = 0; y < 16; y += 4) access(y, 15 - y, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_basic();
        // D_out must be 1 going into the mid-load reset so its clear is visible.
        test_rw();
        test_restore();
        test_load_stall();
        for (int n = 0; n < 16; n++) pat[n] = 16'h0001 << n;
        load_maze(1'b0, 1'b0);
        access(0, 0, 1'b1, 1'b0, 1'b0);
        test_rst_mid_load();
        test_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/maze_memory.md
# maze_memory

Maze storage that sits directly upstream of the maze-solving rat: it holds the 16×16 wall map, answers the rat's single-bit reads at (X,Y), and records the rat's single-bit visited marks. Row-wide loading is done through a ready/valid handshake. A pristine copy of the loaded maze is kept, so the visited marks can be wiped in 16 cycles without reloading.

## Interface
Parameters:
- DIM, 16, maze side length in cells; coordinate width is fixed at 4 bits, so DIM must be 16.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  clock, all state changes on the rising edge
- RST  in  1  asynchronous, active-high reset
- load_start  in  1  begin a full maze load; sampled in IDLE or READY
- row_data  in  16  one maze row; bit x is cell (x, row); 1 means wall/blocked
- row_valid  in  1  row_data is valid
- row_ready  out  1  memory accepts a row this cycle
- clear_marks  in  1  restore the working map from the pristine copy; sampled in READY
- X  in  4  column of the rat access
- Y  in  4  row of the rat access
- RD  in  1  read request for cell (X,Y)
- WR  in  1  write request for cell (X,Y)
- D_in  in  1  write data; 1 marks the cell blocked/visited
- D_out  out  1  registered read data
- ready  out  1  map is loaded and idle; rat accesses are honoured
- access_err  out  1  one-cycle pulse when RD or WR arrives while ready=0

## Operation
- Storage: two 16×16 bit arrays.
  - orig is written only during LOAD.
  - work is written by LOAD, RESTORE and rat WR.
- FSM states: IDLE, LOAD, READY, RESTORE.
  - IDLE: row_ready=0, ready=0. load_start → LOAD with row counter = 0.
  - LOAD: row_ready=1.
    - Each cycle with row_valid=1 writes row_data into orig[row] and work[row], then increments row.
    - Acceptance of row 15 → READY. The row counter wraps to 0.
    - load_start during LOAD is ignored.
  - READY: ready=1; rat accesses are served.
    - load_start → LOAD, row counter reset to 0. The maze is overwritten row by row.
    - clear_marks (with load_start=0) → RESTORE, row counter = 0.
    - load_start and clear_marks in the same cycle: load_start wins.
  - RESTORE: copies orig[row] to work[row], one row per cycle, for rows 0..15, then → READY. Inputs other than RST are ignored.
- Rat read: RD=1 in READY loads D_out ← work[Y][X].
- Rat write: WR=1 in READY sets work[Y][X] ← D_in. orig is never touched.
- RD and WR in the same cycle to the same cell: read-before-write. D_out gets the old value and the new value is stored.
- RD/WR outside READY:
  - no array or D_out change;
  - access_err pulses for one cycle.
- D_out holds its last value when RD=0.

## Timing
- Reset values: state=IDLE, row counter=0, row_ready=0, ready=0, D_out=0, access_err=0. Array contents are unspecified after reset and are not accessible until a load completes.
- RST asserted mid-LOAD or mid-RESTORE aborts immediately to IDLE. A full reload is required.
- Read latency: 1 cycle. RD at edge n produces valid D_out after edge n.
- Write latency: a WR at edge n is visible to an RD at edge n+1.
- Load: minimum 16 cycles, from the first row_valid&row_ready to ready=1 on the cycle after row 15 is accepted. Stalls on row_valid=0 are unbounded.
- Restore: exactly 16 cycles in RESTORE. ready deasserts the cycle after clear_marks is sampled and reasserts after edge 16.
- access_err is registered: it asserts the cycle after the offending edge and lasts one cycle.

## Structure
- Shared package:
  - state encoding (IDLE=2'd0, LOAD=2'd1, READY=2'd2, RESTORE=2'd3);
  - the DIM and COORD_W=4 constants, also used by the rat datapath.
- Sub-module maze_mem_ctrl (the FSM plus the 4-bit row counter) is natural.
- The two arrays and the read register stay in the top.

## Test plan
- Reset, then load 16 rows with row n = 16'h0001<<n and no stalls → ready=1 after exactly 16 accept cycles; RD at (3,3) → D_out=1; RD at (4,3) → D_out=0.
- Load with row_valid toggling every other cycle → exactly 16 rows stored in order; row_ready=0 before load_start and after completion.
- In READY: WR (5,2) with D_in=1, then RD (5,2) next cycle → D_out=1. Same-cycle RD+WR on (6,2) → D_out=0, then a later RD gives 1.
- After marks are written, pulse clear_marks → ready low for 16 cycles; RD (5,2) afterwards → original value 0. RD during RESTORE → access_err pulse and D_out unchanged.
- Assert RST at row 7 of a load → row_ready=0, ready=0, D_out=0 immediately; a fresh 16-row load succeeds. load_start+clear_marks together in READY → enters LOAD.
